// File: rtl/cyclic_decoder_systematic_pkg.sv
// Shared constants and syndrome helpers for the (15,11) cyclic Hamming code, g(x) = x^4 + x + 1.
package cyclic_code_pkg;

    localparam int N = 15;
    localparam int K = 11;
    localparam int R = 4;
    localparam logic [4:0] G = 5'b10011;

    // One LFSR step of the remainder r(x) mod g(x), MSB-first input.
    function automatic logic [3:0] syn_step(input logic [3:0] syn, input logic bit_in);
        syn_step = {syn[2:0], bit_in} ^ (syn[3] ? G[3:0] : 4'b0000);
    endfunction

    // Returns {hit, pos}: syndrome x^pos mod g for a single error at coefficient pos.
    function automatic logic [4:0] syn_to_pos(input logic [3:0] syn);
        case (syn)
            4'b0001: syn_to_pos = {1'b1, 4'd0};
            4'b0010: syn_to_pos = {1'b1, 4'd1};
            4'b0100: syn_to_pos = {1'b1, 4'd2};
            4'b1000: syn_to_pos = {1'b1, 4'd3};
            4'b0011: syn_to_pos = {1'b1, 4'd4};
            4'b0110: syn_to_pos = {1'b1, 4'd5};
            4'b1100: syn_to_pos = {1'b1, 4'd6};
            4'b1011: syn_to_pos = {1'b1, 4'd7};
            4'b0101: syn_to_pos = {1'b1, 4'd8};
            4'b1010: syn_to_pos = {1'b1, 4'd9};
            4'b0111: syn_to_pos = {1'b1, 4'd10};
            4'b1110: syn_to_pos = {1'b1, 4'd11};
            4'b1111: syn_to_pos = {1'b1, 4'd12};
            4'b1101: syn_to_pos = {1'b1, 4'd13};
            4'b1001: syn_to_pos = {1'b1, 4'd14};
            default: syn_to_pos = {1'b0, 4'd0};
        endcase
    endfunction

endpackage

// File: rtl/cyclic_decoder_systematic_syndrome.sv
// Syndrome LFSR: load-first starts a word, clear ends it, step absorbs one code bit.
module cyclic_syndrome_lfsr
    import cyclic_code_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       load_first,
    input  logic       step,
    input  logic       bit_in,
    output logic [3:0] syn,
    output logic [3:0] syn_next
);

    logic [3:0] syn_r;

    assign syn_next = syn_step(syn_r, bit_in);
    assign syn      = syn_r;

    // Syndrome register; a new word's first bit takes priority over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            syn_r <= 4'b0000;
        end else if (load_first) begin
            syn_r <= {3'b000, bit_in};
        end else if (clear) begin
            syn_r <= 4'b0000;
        end else if (step) begin
            syn_r <= syn_next;
        end else begin
            syn_r <= syn_r;
        end
    end

endmodule

// File: rtl/cyclic_decoder_systematic.sv
// Serial single-error-correcting decoder for the systematic (15,11) cyclic Hamming code.
module cyclic_decoder_systematic
    import cyclic_code_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in,
    input  logic        sof,
    output logic        out,
    output logic        out_valid,
    output logic        out_first,
    output logic        err_corrected,
    output logic [3:0]  err_pos,
    output logic [15:0] corr_count
);

    logic [3:0]  bit_cnt_r;
    logic [13:0] rx_word_r;      // c14..c1 once 14 bits are in; c0 arrives on the final cycle
    logic [3:0]  syn_s;
    logic [3:0]  syn_next_s;
    logic        final_s;
    logic [14:0] word_s;
    logic [4:0]  lookup_s;
    logic [14:0] corrected_s;
    logic        unused_parity_s;

    logic [10:0] tx_shift_r;
    logic [3:0]  tx_cnt_r;
    logic        out_r;
    logic        out_valid_r;
    logic        out_first_r;
    logic        err_corrected_r;
    logic [3:0]  err_pos_r;
    logic [15:0] corr_count_r;

    assign final_s  = in_valid & ~sof & (bit_cnt_r == 4'd14);
    assign word_s   = {rx_word_r, in};
    assign lookup_s = syn_to_pos(syn_next_s);

    cyclic_syndrome_lfsr u_syn (
        .clk        (clk),
        .reset      (reset),
        .clear      (final_s),
        .load_first (in_valid & sof),
        .step       (in_valid),
        .bit_in     (in),
        .syn        (syn_s),
        .syn_next   (syn_next_s)
    );

    // Single-bit correction of the completed word; every nonzero syndrome maps to a position.
    always_comb begin
        corrected_s = word_s;
        if (lookup_s[4]) begin
            corrected_s = word_s ^ (15'd1 << lookup_s[3:0]);
        end else begin
            corrected_s = word_s;
        end
    end

    // Parity bits are only needed for the syndrome, never for the message output.
    assign unused_parity_s = ^{corrected_s[3:0], syn_s};

    // Receive stage: bit counter and word shift register, frozen while in_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_r <= 4'd0;
            rx_word_r <= 14'd0;
        end else if (in_valid) begin
            if (sof) begin
                bit_cnt_r <= 4'd1;
                rx_word_r <= {13'd0, in};
            end else if (bit_cnt_r == 4'd14) begin
                bit_cnt_r <= 4'd0;
                rx_word_r <= 14'd0;
            end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
                rx_word_r <= {rx_word_r[12:0], in};
            end
        end else begin
            bit_cnt_r <= bit_cnt_r;
            rx_word_r <= rx_word_r;
        end
    end

    // Transmit stage: m10 is registered straight onto out at load, the other ten bits follow.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_shift_r  <= 11'd0;
            tx_cnt_r    <= 4'd0;
            out_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_first_r <= 1'b0;
        end else if (final_s) begin
            tx_shift_r  <= {corrected_s[13:4], 1'b0};
            tx_cnt_r    <= 4'd10;
            out_r       <= corrected_s[14];
            out_valid_r <= 1'b1;
            out_first_r <= 1'b1;
        end else if (tx_cnt_r != 4'd0) begin
            tx_shift_r  <= {tx_shift_r[9:0], 1'b0};
            tx_cnt_r    <= tx_cnt_r - 4'd1;
            out_r       <= tx_shift_r[10];
            out_valid_r <= 1'b1;
            out_first_r <= 1'b0;
        end else begin
            tx_shift_r  <= tx_shift_r;
            tx_cnt_r    <= 4'd0;
            out_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_first_r <= 1'b0;
        end
    end

    // Per-word status, held until the next word loads, plus the saturating correction count.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_corrected_r <= 1'b0;
            err_pos_r       <= 4'd0;
            corr_count_r    <= 16'd0;
        end else if (final_s) begin
            err_corrected_r <= lookup_s[4];
            err_pos_r       <= lookup_s[3:0];
            if (lookup_s[4] && (corr_count_r != 16'hFFFF)) begin
                corr_count_r <= corr_count_r + 16'd1;
            end else begin
                corr_count_r <= corr_count_r;
            end
        end else begin
            err_corrected_r <= err_corrected_r;
            err_pos_r       <= err_pos_r;
            corr_count_r    <= corr_count_r;
        end
    end

    assign out           = out_r;
    assign out_valid     = out_valid_r;
    assign out_first     = out_first_r;
    assign err_corrected = err_corrected_r;
    assign err_pos       = err_pos_r;
    assign corr_count    = corr_count_r;

endmodule

// File: tb/tb_cyclic_decoder_systematic.sv
// Randomised scoreboard bench for cyclic_decoder_systematic using a polynomial-division reference.
module tb_cyclic_decoder_systematic;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in = 1'b0;
    logic        sof = 1'b0;
    logic        out;
    logic        out_valid;
    logic        out_first;
    logic        err_corrected;
    logic [3:0]  err_pos;
    logic [15:0] corr_count;

    cyclic_decoder_systematic dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in            (in),
        .sof           (sof),
        .out           (out),
        .out_valid     (out_valid),
        .out_first     (out_first),
        .err_corrected (err_corrected),
        .err_pos       (err_pos),
        .corr_count    (corr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] msg;
        logic        err;
        logic [3:0]  pos;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          n_cmp = 0;
    int          n_err = 0;
    int          mon_bits = 0;
    logic [10:0] mon_shift = 11'd0;
    logic [15:0] exp_cnt = 16'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Remainder of v(x) mod g(x) by long division.
    function automatic logic [3:0] poly_rem(input logic [14:0] v);
        logic [14:0] t;
        t = v;
        for (int i = 14; i >= 4; i--)
            if (t[i]) t = t ^ (15'b000000000010011 << (i - 4));
        return t[3:0];
    endfunction

    function automatic logic [14:0] encode(input logic [10:0] m);
        logic [14:0] c;
        c = {m, 4'b0000};
        return c | {11'd0, poly_rem(c)};
    endfunction

    // Returns {msg, err, pos}: search for the error position whose x^j mod g matches.
    function automatic logic [15:0] model_decode(input logic [14:0] r);
        logic [3:0]  s;
        logic [14:0] fixed;
        logic [3:0]  p;
        s = poly_rem(r);
        fixed = r;
        p = 4'd0;
        if (s != 4'd0) begin
            for (int j = 0; j < 15; j++) begin
                if (poly_rem(15'd1 << j) == s) begin
                    fixed = r ^ (15'd1 << j);
                    p = 4'(j);
                end
            end
        end
        return {fixed[14:4], (s != 4'd0), p};
    endfunction

    task automatic push_expected(input logic [10:0] msg, input logic err, input logic [3:0] pos);
        if (err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        exp_q.push_back({msg, err, pos, exp_cnt});
    endtask

    task automatic send_bit(input logic b, input logic s);
        in = b;
        sof = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sof = 1'b0;
        in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_word(input logic [14:0] w, input logic use_sof, input int gap_max,
                              input logic [10:0] msg, input logic err, input logic [3:0] pos);
        for (int i = 14; i >= 0; i--) begin
            if (gap_max > 0 && $urandom_range(0, 2) == 0) idle($urandom_range(1, gap_max));
            if (i == 0) push_expected(msg, err, pos);
            send_bit(w[i], use_sof && (i == 14));
        end
    endtask

    task automatic send_random(input logic use_sof, input int gap_max, input logic force_err);
        logic [10:0] m;
        logic [14:0] r;
        logic [15:0] d;
        m = 11'($urandom);
        r = encode(m);
        if (force_err || $urandom_range(0, 3) != 0) r = r ^ (15'd1 << $urandom_range(0, 14));
        d = model_decode(r);
        drive_word(r, use_sof, gap_max, d[15:5], d[4], d[3:0]);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (exp_q.size() != 0 || mon_bits != 0); k++) @(negedge clk);
        @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Output monitor: reassembles each burst and compares it with the queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            mon_bits = 0;
            exp_q.delete();
        end else if (out_valid) begin
            if (out_first) begin
                check("burst_short", mon_bits, 0);
                check("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("err_corrected", err_corrected, cur.err);
                    check("err_pos", err_pos, cur.pos);
                    check("corr_count", corr_count, cur.cnt);
                end
                mon_shift = {10'd0, out};
                mon_bits = 1;
            end else begin
                check("stray_bit", mon_bits != 0, 1);
                if (mon_bits != 0) begin
                    mon_shift = {mon_shift[9:0], out};
                    mon_bits++;
                    check("status_hold", {err_corrected, err_pos}, {cur.err, cur.pos});
                    if (mon_bits == 11) begin
                        check("message", mon_shift, cur.msg);
                        mon_bits = 0;
                    end
                end
            end
        end else if (mon_bits != 0) begin
            check("burst_gap", mon_bits, 0);
            mon_bits = 0;
        end
    end

    initial begin
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_first", out_first, 0);
        check("rst_err_corrected", err_corrected, 0);
        check("rst_err_pos", err_pos, 0);
        check("rst_corr_count", corr_count, 0);
        @(posedge clk);
        #1;

        // Directed words with hand-derived expectations.
        drive_word(15'b100000000001001, 1'b1, 0, 11'b10000000000, 1'b0, 4'd0);
        drive_word(15'b100000010001001, 1'b1, 0, 11'b10000000000, 1'b1, 4'd7);
        drive_word(15'h7FFE, 1'b1, 0, 11'h7FF, 1'b1, 4'd0);
        drive_word(15'h3FFF, 1'b1, 0, 11'h7FF, 1'b1, 4'd14);
        drain();

        // Back-to-back continuous stream, then random in_valid gaps.
        for (int w = 0; w < 30; w++) send_random(1'($urandom_range(0, 1)), 0, 1'b0);
        for (int w = 0; w < 30; w++) send_random(1'($urandom_range(0, 1)), 3, 1'b0);
        drain();

        // Partial word aborted by sof, then a complete word.
        for (int i = 0; i < 6; i++) send_bit(1'($urandom), i == 0);
        send_random(1'b1, 0, 1'b1);
        drain();

        // Reset in the middle of an output burst.
        send_random(1'b1, 0, 1'b1);
        for (int k = 0; k < 40 && mon_bits != 6; k++) idle(1);
        check("reach_mid_burst", mon_bits, 6);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_cnt = 16'd0;
        @(negedge clk);
        check("midrst_out", out, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_first", out_first, 0);
        check("midrst_err_corrected", err_corrected, 0);
        check("midrst_err_pos", err_pos, 0);
        check("midrst_corr_count", corr_count, 0);
        @(posedge clk);
        #1;
        send_random(1'b0, 0, 1'b1);
        drain();

        // Saturation: preload the counter close to its ceiling, then correct more words.
        force dut.corr_count_r = 16'hFFFC;
        @(posedge clk);
        #1;
        release dut.corr_count_r;
        exp_cnt = 16'hFFFC;
        for (int w = 0; w < 6; w++) send_random(1'b1, 0, 1'b1);
        drain();
        check("corr_count_saturated", corr_count, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
